branch_target_calc: RTL and testbench
=====================================

# branch_target_calc

Parametrised, pipelined branch/jump target calculator for the RISC-V core. It computes PC-relative branch/JAL targets, register-relative JALR targets, the sequential PC, and the link address. Results carry a misalignment flag and pass through 1 or 2 register stages under a valid/ready handshake, with global enable and flush. It sits between decode and the fetch redirect logic and supersedes the single-register target adder.

## Interface
- XLEN, 32, address/operand width
- IMM_SHIFT, 2, left shift applied to the immediate in modes BR and JAL
- ALIGN_BYTES, 4, required target alignment (power of two, ≥2; 2 for compressed ISA)
- PIPE_STAGES, 1, register stages (1 or 2); latency in cycles
- TAG_W, 4, width of sideband tag carried with each result
- i_Clk  in  1  clock
- i_Rst  in  1  reset, asynchronous, active-high; clock i_Clk
- i_Enb  in  1  global enable; low freezes all state
- i_Flush  in  1  drop all in-flight results and the current input
- i_Valid  in  1  input request valid
- o_Ready  out  1  block can accept input this cycle
- iv_Mode  in  2  00 BR, 01 JAL, 10 JALR, 11 SEQ
- iv_Pc  in  XLEN  current PC
- iv_Rs1  in  XLEN  base register (JALR only)
- iv_Imm  in  XLEN  sign-extended immediate
- iv_Tag  in  TAG_W  sideband tag
- o_Valid  out  1  result valid
- i_Ready  in  1  consumer accepts result
- ov_Target  out  XLEN  computed target
- ov_Link  out  XLEN  iv_Pc + 4
- o_Misalign  out  1  target not ALIGN_BYTES-aligned
- ov_Tag  out  TAG_W  tag of the result

## Operation
- All arithmetic is modulo 2^XLEN; carries out of bit XLEN-1 are discarded.
- BR and JAL: target = iv_Pc + (iv_Imm << IMM_SHIFT). Shifted-out upper bits are dropped.
- JALR: target = (iv_Rs1 + iv_Imm) with bit 0 forced to 0. No shift is applied.
- SEQ: target = iv_Pc + 4.
- Link = iv_Pc + 4 in every mode.
- o_Misalign = |(target & (ALIGN_BYTES-1)), evaluated on the final target (after the JALR bit-0 clear).
- PIPE_STAGES=1: the result is computed combinationally and captured in the output stage.
- PIPE_STAGES=2: stage 1 registers mode, operands and tag; stage 2 computes and registers the result.
- Each stage holds a valid bit. A stage can load when it is empty or its downstream consumer takes its data in the same cycle.
- o_Ready = i_Enb & !i_Flush & (stage-1 empty | stage-1 advancing).
- Transfer in: i_Valid & o_Ready. Transfer out: o_Valid & i_Ready & i_Enb.
- o_Valid is asserted only while the final stage holds a result.
- i_Enb=0: no transfer in or out; all registers hold; o_Ready=0. o_Valid and data stay unchanged.
- i_Flush=1: all valid bits clear at the next edge, regardless of i_Enb. The input in that cycle is not accepted. Data registers may retain stale values.
- Back-pressure: while o_Valid & !i_Ready, ov_Target, ov_Link, o_Misalign and ov_Tag are held stable.
- Simultaneous full and drain: a stage that is full and draining accepts new data in the same cycle, so throughput is one result per cycle with no bubble.

## Timing
- Reset (async): all valid bits and all data registers go to 0. So o_Valid=0, ov_Target=0, ov_Link=0, o_Misalign=0, ov_Tag=0. o_Ready follows its equation and is 1 after reset if i_Enb=1 and i_Flush=0.
- Latency: an input accepted at edge N appears on the outputs after edge N+PIPE_STAGES-1. It is visible with o_Valid=1 in cycle N+PIPE_STAGES, counting edge N as cycle 0.
- Throughput: 1 result per cycle when i_Ready=1 and i_Enb=1.
- Reset asserted mid-operation clears everything immediately. In-flight results are lost and none are emitted.
- i_Flush and a transfer out in the same cycle: the transfer out completes. The consumer saw o_Valid and i_Ready, and the stage still clears.
- No combinational path from i_Valid to o_Valid. o_Ready depends combinationally on i_Ready, i_Enb and i_Flush only.

## Test plan
- Reset, then BR with Pc=0x0000_1000, Imm=0x10, IMM_SHIFT=2 -> Target=0x0000_1040, Link=0x0000_1004, Misalign=0, o_Valid one cycle after accept.
- JALR with Rs1=0x0000_2003, Imm=0x0 -> Target=0x0000_2002, Misalign=1 at ALIGN_BYTES=4 and Misalign=0 at ALIGN_BYTES=2.
- Wrap: BR with Pc=0xFFFF_FFF0, Imm=0x8 -> Target=0x0000_0010. BR with Imm=0xFFFF_FFFF (-1) at Pc=0x100 -> Target=0x0000_00FC.
- Back-pressure, PIPE_STAGES=2: stream tags 1..5 with i_Ready low for 3 cycles mid-stream -> outputs held stable, no tag lost or duplicated, order 1..5, o_Ready drops once both stages are full.
- Enable/flush: i_Enb=0 for 2 cycles with o_Valid=1 -> outputs frozen. Then i_Flush with 2 results in flight -> o_Valid=0 next cycle and the flush-cycle input is not accepted.
- Async reset asserted between clock edges while o_Valid=1 -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - pipelined branch/jump target calculator
// Computes BR/JAL/JALR/SEQ targets, link address and misalignment behind a valid/ready pipe.
module branch_target_calc #(
  parameter int XLEN        = 32,
  parameter int IMM_SHIFT   = 2,
  parameter int ALIGN_BYTES = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Enb,
  input  logic             i_Flush,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [1:0]       iv_Mode,
  input  logic [XLEN-1:0]  iv_Pc,
  input  logic [XLEN-1:0]  iv_Rs1,
  input  logic [XLEN-1:0]  iv_Imm,
  input  logic [TAG_W-1:0] iv_Tag,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [XLEN-1:0]  ov_Target,
  output logic [XLEN-1:0]  ov_Link,
  output logic             o_Misalign,
  output logic [TAG_W-1:0] ov_Tag
);

  typedef enum logic [1:0] {
    MODE_BR   = 2'b00,
    MODE_JAL  = 2'b01,
    MODE_JALR = 2'b10,
    MODE_SEQ  = 2'b11
  } mode_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] BIT0_CLR   = {{(XLEN-1){1'b1}}, 1'b0};

  // Operands presented to the compute/output stage (raw inputs or stage-1 registers)
  logic             calc_valid;
  logic [1:0]       calc_mode;
  logic [XLEN-1:0]  calc_pc;
  logic [XLEN-1:0]  calc_rs1;
  logic [XLEN-1:0]  calc_imm;
  logic [TAG_W-1:0] calc_tag;

  logic [XLEN-1:0]  calc_target;
  logic [XLEN-1:0]  calc_link;
  logic             calc_misalign;

  logic             out_free;
  logic             out_take;
  logic             xfer_out;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [XLEN-1:0]  link_q, link_d;
  logic             misalign_q, misalign_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    calc_link   = calc_pc + PC_STEP;
    calc_target = calc_link;
    case (calc_mode)
      MODE_BR, MODE_JAL: calc_target = calc_pc + (calc_imm << IMM_SHIFT);
      MODE_JALR:         calc_target = (calc_rs1 + calc_imm) & BIT0_CLR;
      default:           calc_target = calc_link;
    endcase
    calc_misalign = |(calc_target & ALIGN_MASK);
  end

  // Output stage refills in the same cycle it drains, so a full pipe never bubbles
  assign out_free = !out_valid_q || i_Ready;
  assign out_take = i_Enb && !i_Flush && calc_valid && out_free;
  assign xfer_out = out_valid_q && i_Ready && i_Enb;

  always_comb begin
    out_valid_d = out_valid_q;
    target_d    = target_q;
    link_d      = link_q;
    misalign_d  = misalign_q;
    tag_d       = tag_q;
    if (out_take) begin
      out_valid_d = 1'b1;
      target_d    = calc_target;
      link_d      = calc_link;
      misalign_d  = calc_misalign;
      tag_d       = calc_tag;
    end else if (xfer_out) begin
      out_valid_d = 1'b0;
    end
    if (i_Flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      out_valid_q <= 1'b0;
      target_q    <= '0;
      link_q      <= '0;
      misalign_q  <= 1'b0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      target_q    <= target_d;
      link_q      <= link_d;
      misalign_q  <= misalign_d;
      tag_q       <= tag_d;
    end
  end

  generate
    if (PIPE_STAGES == 2) begin : g_two_stage
      logic             s1_valid_q, s1_valid_d;
      logic [1:0]       s1_mode_q, s1_mode_d;
      logic [XLEN-1:0]  s1_pc_q, s1_pc_d;
      logic [XLEN-1:0]  s1_rs1_q, s1_rs1_d;
      logic [XLEN-1:0]  s1_imm_q, s1_imm_d;
      logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
      logic             xfer_in;

      // Stage 1 advances exactly when the output stage takes its contents
      assign o_Ready = i_Enb && !i_Flush && (!s1_valid_q || out_free);
      assign xfer_in = i_Valid && o_Ready;

      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_pc_d    = s1_pc_q;
        s1_rs1_d   = s1_rs1_q;
        s1_imm_d   = s1_imm_q;
        s1_tag_d   = s1_tag_q;
        if (xfer_in) begin
          s1_valid_d = 1'b1;
          s1_mode_d  = iv_Mode;
          s1_pc_d    = iv_Pc;
          s1_rs1_d   = iv_Rs1;
          s1_imm_d   = iv_Imm;
          s1_tag_d   = iv_Tag;
        end else if (out_take) begin
          s1_valid_d = 1'b0;
        end
        if (i_Flush) begin
          s1_valid_d = 1'b0;
        end
      end

      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          s1_valid_q <= 1'b0;
          s1_mode_q  <= '0;
          s1_pc_q    <= '0;
          s1_rs1_q   <= '0;
          s1_imm_q   <= '0;
          s1_tag_q   <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_mode_q  <= s1_mode_d;
          s1_pc_q    <= s1_pc_d;
          s1_rs1_q   <= s1_rs1_d;
          s1_imm_q   <= s1_imm_d;
          s1_tag_q   <= s1_tag_d;
        end
      end

      assign calc_valid = s1_valid_q;
      assign calc_mode  = s1_mode_q;
      assign calc_pc    = s1_pc_q;
      assign calc_rs1   = s1_rs1_q;
      assign calc_imm   = s1_imm_q;
      assign calc_tag   = s1_tag_q;
    end else begin : g_one_stage
      assign o_Ready    = i_Enb && !i_Flush && out_free;
      assign calc_valid = i_Valid;
      assign calc_mode  = iv_Mode;
      assign calc_pc    = iv_Pc;
      assign calc_rs1   = iv_Rs1;
      assign calc_imm   = iv_Imm;
      assign calc_tag   = iv_Tag;
    end
  endgenerate

  assign o_Valid    = out_valid_q;
  assign ov_Target  = target_q;
  assign ov_Link    = link_q;
  assign o_Misalign = misalign_q;
  assign ov_Tag     = tag_q;

endmodule

// File: tb/tb_branch_target_calc.sv
// tb/tb_branch_target_calc.sv - self-checking bench for branch_target_calc
// Three instances share stimulus: 1-stage/align4, 2-stage/align4, 1-stage/align2.
module tb_branch_target_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enb = 1'b1;
  logic        flush = 1'b0;
  logic        vld_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [31:0] pc = '0, rs1 = '0, imm = '0;
  logic [3:0]  tag = '0;

  logic        a_ready, a_valid, a_mis, b_ready, b_valid, b_mis, c_ready, c_valid, c_mis;
  logic [31:0] a_target, a_link, b_target, b_link, c_target, c_link;
  logic [3:0]  a_tag, b_tag, c_tag;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_target_calc #(.XLEN(32), .IMM_SHIFT(2), .ALIGN_BYTES(4), .PIPE_STAGES(1), .TAG_W(4)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Enb(enb), .i_Flush(flush), .i_Valid(vld_in), .o_Ready(a_ready),
    .iv_Mode(mode), .iv_Pc(pc), .iv_Rs1(rs1), .iv_Imm(imm), .iv_Tag(tag), .o_Valid(a_valid),
    .i_Ready(rdy_in), .ov_Target(a_target), .ov_Link(a_link), .o_Misalign(a_mis), .ov_Tag(a_tag));

  branch_target_calc #(.XLEN(32), .IMM_SHIFT(2), .ALIGN_BYTES(4), .PIPE_STAGES(2), .TAG_W(4)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Enb(enb), .i_Flush(flush), .i_Valid(vld_in), .o_Ready(b_ready),
    .iv_Mode(mode), .iv_Pc(pc), .iv_Rs1(rs1), .iv_Imm(imm), .iv_Tag(tag), .o_Valid(b_valid),
    .i_Ready(rdy_in), .ov_Target(b_target), .ov_Link(b_link), .o_Misalign(b_mis), .ov_Tag(b_tag));

  branch_target_calc #(.XLEN(32), .IMM_SHIFT(2), .ALIGN_BYTES(2), .PIPE_STAGES(1), .TAG_W(4)) dut_c (
    .i_Clk(clk), .i_Rst(rst), .i_Enb(enb), .i_Flush(flush), .i_Valid(vld_in), .o_Ready(c_ready),
    .iv_Mode(mode), .iv_Pc(pc), .iv_Rs1(rs1), .iv_Imm(imm), .iv_Tag(tag), .o_Valid(c_valid),
    .i_Ready(rdy_in), .ov_Target(c_target), .ov_Link(c_link), .o_Misalign(c_mis), .ov_Tag(c_tag));

  // Reference model: an in-order list of accepted results per pipeline depth.
  // A result becomes visible once it has seen (depth-1) enabled edges after acceptance.
  typedef struct {
    logic [31:0] target;
    logic [31:0] link;
    logic        mis4;
    logic        mis2;
    logic [3:0]  tag;
    int          age;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t f1, f2;
  logic m1_ready, m2_ready, m1_valid, m2_valid;

  function automatic exp_t ref_calc(logic [1:0] m, logic [31:0] p, logic [31:0] r, logic [31:0] i, logic [3:0] t);
    exp_t e;
    logic [31:0] tgt;
    case (m)
      2'd0, 2'd1: tgt = p + i * 32'd4;
      2'd2:       tgt = (r + i) & 32'hFFFF_FFFE;
      default:    tgt = p + 32'd4;
    endcase
    e.target = tgt;
    e.link   = p + 32'd4;
    e.mis4   = (tgt % 4) != 0;
    e.mis2   = (tgt % 2) != 0;
    e.tag    = t;
    e.age    = 0;
    return e;
  endfunction

  task automatic sample();
    @(negedge clk);
    m1_ready = enb && !flush && (q1.size() < 1 || rdy_in);
    m2_ready = enb && !flush && (q2.size() < 2 || rdy_in);
    m1_valid = q1.size() > 0;
    m2_valid = q2.size() > 0 && q2[0].age >= 1;
    if (m1_valid) f1 = q1[0];
    if (m2_valid) f2 = q2[0];
  endtask

  task automatic advance();
    exp_t e;
    e = ref_calc(mode, pc, rs1, imm, tag);
    @(posedge clk);
    if (flush) begin
      q1.delete();
      q2.delete();
    end else if (enb) begin
      if (m1_valid && rdy_in) void'(q1.pop_front());
      foreach (q1[i]) q1[i].age = q1[i].age + 1;
      if (vld_in && m1_ready) q1.push_back(e);
      if (m2_valid && rdy_in) void'(q2.pop_front());
      foreach (q2[i]) q2[i].age = q2[i].age + 1;
      if (vld_in && m2_ready) q2.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_valid, a_target, a_link, a_mis, a_tag, b_valid, b_target, b_link, b_mis, b_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: a v=%b t=%h l=%h m=%b g=%h b v=%b t=%h l=%h m=%b g=%h required all 0",
               a_valid, a_target, a_link, a_mis, a_tag, b_valid, b_target, b_link, b_mis, b_tag);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    q1.delete();
    q2.delete();
    sample();
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: a_ready=%b b_ready=%b a_valid=%b b_valid=%b required 1 1 0 0", a_ready, b_ready, a_valid, b_valid);
    end
    advance();
  endtask

  task automatic test_br_basic();
    mode = 2'b00; pc = 32'h0000_1000; imm = 32'h10; rs1 = '0; tag = 4'h3; vld_in = 1'b1; rdy_in = 1'b1;
    sample();
    advance();
    vld_in = 1'b0;
    sample();
    n_checks++;
    if (a_valid !== 1'b1 || a_target !== 32'h0000_1040 || a_link !== 32'h0000_1004 || a_mis !== 1'b0 || a_tag !== 4'h3) begin
      n_fail++;
      $display("FAIL br_stage1: v=%b t=%h l=%h m=%b g=%h required 1 00001040 00001004 0 3", a_valid, a_target, a_link, a_mis, a_tag);
    end
    n_checks++;
    if (b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL br_stage2_early: o_Valid=%b required 0", b_valid);
    end
    advance();
    sample();
    n_checks++;
    if (b_valid !== 1'b1 || b_target !== 32'h0000_1040 || b_link !== 32'h0000_1004 || b_mis !== 1'b0 || b_tag !== 4'h3) begin
      n_fail++;
      $display("FAIL br_stage2: v=%b t=%h l=%h m=%b g=%h required 1 00001040 00001004 0 3", b_valid, b_target, b_link, b_mis, b_tag);
    end
    n_checks++;
    if (a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL br_drain: o_Valid=%b required 0", a_valid);
    end
    advance();
  endtask

  task automatic test_jalr_misalign();
    mode = 2'b10; pc = 32'h0000_0400; rs1 = 32'h0000_2003; imm = 32'h0; tag = 4'h5; vld_in = 1'b1; rdy_in = 1'b1;
    sample();
    advance();
    vld_in = 1'b0;
    sample();
    n_checks++;
    if (a_valid !== 1'b1 || a_target !== 32'h0000_2002 || a_mis !== 1'b1 || a_link !== 32'h0000_0404) begin
      n_fail++;
      $display("FAIL jalr_align4: v=%b t=%h m=%b l=%h required 1 00002002 1 00000404", a_valid, a_target, a_mis, a_link);
    end
    n_checks++;
    if (c_valid !== 1'b1 || c_target !== 32'h0000_2002 || c_mis !== 1'b0) begin
      n_fail++;
      $display("FAIL jalr_align2: v=%b t=%h m=%b required 1 00002002 0", c_valid, c_target, c_mis);
    end
    advance();
    sample();
    advance();
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [2];
    logic [31:0] imms [2];
    logic [31:0] exps [2];
    pcs[0] = 32'hFFFF_FFF0; imms[0] = 32'h8;         exps[0] = 32'h0000_0010;
    pcs[1] = 32'h0000_0100; imms[1] = 32'hFFFF_FFFF; exps[1] = 32'h0000_00FC;
    for (int i = 0; i < 2; i++) begin
      mode = 2'b00; pc = pcs[i]; imm = imms[i]; tag = 4'(i + 8); vld_in = 1'b1; rdy_in = 1'b1;
      sample();
      advance();
      vld_in = 1'b0;
      sample();
      n_checks++;
      if (a_valid !== 1'b1 || a_target !== exps[i] || a_link !== pcs[i] + 32'd4) begin
        n_fail++;
        $display("FAIL wrap_%0d: v=%b t=%h l=%h required 1 %h %h", i, a_valid, a_target, a_link, exps[i], pcs[i] + 32'd4);
      end
      advance();
      sample();
      advance();
    end
  endtask

  task automatic test_back_pressure();
    int next_tag = 1;
    int got = 0;
    int cyc = 0;
    logic [3:0] exp_tag = 4'd1;
    bit saw_stall = 1'b0;
    bit hold_prev = 1'b0;
    logic [31:0] prev_t = '0;
    logic [3:0] prev_g = '0;
    while (got < 5 && cyc < 40) begin
      vld_in = (next_tag <= 5);
      mode = 2'($urandom_range(0, 3)); pc = $urandom; rs1 = $urandom; imm = $urandom; tag = 4'(next_tag);
      rdy_in = !(cyc >= 3 && cyc < 6);
      sample();
      if (vld_in && !b_ready) saw_stall = 1'b1;
      n_checks++;
      if (b_ready !== m2_ready || b_valid !== m2_valid) begin
        n_fail++;
        $display("FAIL bp_handshake cyc %0d: ready=%b valid=%b required %b %b", cyc, b_ready, b_valid, m2_ready, m2_valid);
      end
      n_checks++;
      if (m2_valid && (b_target !== f2.target || b_tag !== f2.tag || b_mis !== f2.mis4)) begin
        n_fail++;
        $display("FAIL bp_data cyc %0d: t=%h g=%h m=%b required %h %h %b", cyc, b_target, b_tag, b_mis, f2.target, f2.tag, f2.mis4);
      end
      n_checks++;
      if (hold_prev && (b_target !== prev_t || b_tag !== prev_g)) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: t=%h g=%h required %h %h", cyc, b_target, b_tag, prev_t, prev_g);
      end
      hold_prev = b_valid && !rdy_in;
      prev_t = b_target;
      prev_g = b_tag;
      if (b_valid && rdy_in) begin
        n_checks++;
        if (b_tag !== exp_tag) begin
          n_fail++;
          $display("FAIL bp_order: tag=%0d required %0d", b_tag, exp_tag);
        end
        exp_tag++;
        got++;
      end
      if (vld_in && m2_ready) next_tag++;
      advance();
      cyc++;
    end
    n_checks++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL bp_timeout: results=%0d required 5", got);
    end
    n_checks++;
    if (saw_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_drop: saw=%b required 1", saw_stall);
    end
    vld_in = 1'b0; rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic test_enable_flush();
    logic [31:0] ta, tb;
    logic [3:0] ga, gb;
    rdy_in = 1'b0; vld_in = 1'b1; mode = 2'b11; pc = 32'h0000_3000; tag = 4'h7;
    sample();
    advance();
    mode = 2'b01; pc = 32'h0000_4000; imm = 32'h4; tag = 4'h8;
    sample();
    advance();
    sample();
    n_checks++;
    if (a_valid !== 1'b1 || b_valid !== 1'b1 || a_tag !== 4'h7 || b_tag !== 4'h7 || b_target !== 32'h0000_3004) begin
      n_fail++;
      $display("FAIL ef_setup: a_v=%b b_v=%b a_g=%h b_g=%h b_t=%h required 1 1 7 7 00003004", a_valid, b_valid, a_tag, b_tag, b_target);
    end
    ta = a_target; tb = b_target; ga = a_tag; gb = b_tag;
    advance();
    enb = 1'b0; rdy_in = 1'b1; tag = 4'h9; pc = 32'h0000_5000;
    for (int i = 0; i < 2; i++) begin
      sample();
      n_checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || a_valid !== 1'b1 || b_valid !== 1'b1 ||
          a_target !== ta || b_target !== tb || a_tag !== ga || b_tag !== gb) begin
        n_fail++;
        $display("FAIL ef_freeze_%0d: rdy=%b%b v=%b%b t=%h %h g=%h %h required 00 11 %h %h %h %h",
                 i, a_ready, b_ready, a_valid, b_valid, a_target, b_target, a_tag, b_tag, ta, tb, ga, gb);
      end
      advance();
    end
    enb = 1'b1; rdy_in = 1'b0; flush = 1'b1; vld_in = 1'b1; tag = 4'hA;
    sample();
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ef_flush_ready: a=%b b=%b required 0 0", a_ready, b_ready);
    end
    advance();
    flush = 1'b0; vld_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      n_checks++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ef_flushed_%0d: a_v=%b b_v=%b required 0 0", i, a_valid, b_valid);
      end
      advance();
    end
    rdy_in = 1'b1;
  endtask

  task automatic test_async_reset();
    rdy_in = 1'b0; vld_in = 1'b1; mode = 2'b00; pc = 32'h0000_6000; imm = 32'h3; tag = 4'hC;
    sample();
    advance();
    vld_in = 1'b0;
    sample();
    advance();
    sample();
    n_checks++;
    if (a_valid !== 1'b1 || b_valid !== 1'b1 || b_target !== 32'h0000_600C) begin
      n_fail++;
      $display("FAIL ar_setup: a_v=%b b_v=%b b_t=%h required 1 1 0000600c", a_valid, b_valid, b_target);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_valid, a_target, a_link, a_mis, a_tag, b_valid, b_target, b_link, b_mis, b_tag, c_valid, c_target} !== '0) begin
      n_fail++;
      $display("FAIL ar_clear: a v=%b t=%h l=%h g=%h b v=%b t=%h l=%h g=%h c v=%b required all 0",
               a_valid, a_target, a_link, a_tag, b_valid, b_target, b_link, b_tag, c_valid);
    end
    q1.delete();
    q2.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_in = 1'b1;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      enb    = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 24) == 0);
      vld_in = ($urandom_range(0, 3) != 0);
      rdy_in = ($urandom_range(0, 3) != 0);
      mode   = 2'($urandom_range(0, 3));
      pc     = $urandom;
      rs1    = $urandom;
      imm    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(12'($urandom)));
      tag    = 4'($urandom);
      sample();
      n_checks++;
      if (a_ready !== m1_ready || b_ready !== m2_ready || c_ready !== m1_ready ||
          a_valid !== m1_valid || b_valid !== m2_valid || c_valid !== m1_valid) begin
        n_fail++;
        $display("FAIL rnd_handshake cyc %0d: rdy=%b%b%b v=%b%b%b required %b%b%b %b%b%b", cyc,
                 a_ready, b_ready, c_ready, a_valid, b_valid, c_valid, m1_ready, m2_ready, m1_ready, m1_valid, m2_valid, m1_valid);
      end
      n_checks++;
      if (m1_valid && ({a_target, a_link, a_mis, a_tag} !== {f1.target, f1.link, f1.mis4, f1.tag} ||
                       {c_target, c_link, c_mis, c_tag} !== {f1.target, f1.link, f1.mis2, f1.tag})) begin
        n_fail++;
        $display("FAIL rnd_data1 cyc %0d: a t=%h l=%h m=%b g=%h c m=%b required t=%h l=%h m4=%b m2=%b g=%h", cyc,
                 a_target, a_link, a_mis, a_tag, c_mis, f1.target, f1.link, f1.mis4, f1.mis2, f1.tag);
      end
      n_checks++;
      if (m2_valid && {b_target, b_link, b_mis, b_tag} !== {f2.target, f2.link, f2.mis4, f2.tag}) begin
        n_fail++;
        $display("FAIL rnd_data2 cyc %0d: t=%h l=%h m=%b g=%h required %h %h %b %h", cyc,
                 b_target, b_link, b_mis, b_tag, f2.target, f2.link, f2.mis4, f2.tag);
      end
      advance();
    end
    enb = 1'b1; flush = 1'b0; vld_in = 1'b0; rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      n_checks++;
      if (m2_valid && b_tag !== f2.tag) begin
        n_fail++;
        $display("FAIL rnd_drain_tag: %h required %h", b_tag, f2.tag);
      end
      advance();
    end
    sample();
    n_checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0 || q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_empty: a_v=%b b_v=%b model=%0d/%0d required 0 0 0/0", a_valid, b_valid, q1.size(), q2.size());
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_br_basic();
    test_jalr_misalign();
    test_wrap();
    test_back_pressure();
    test_enable_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
